// File: rtl/digit_twos_in.sv
// -----------------------------------------------------------------------------
// digit_twos_in
//
// Keypad-side counterpart of the sign/magnitude display path. Decimal digits
// arrive serially (most significant first) together with a sign-toggle pulse,
// an enter pulse and a clear pulse. The block accumulates the magnitude,
// applies the sign and emits a two's-complement int16_t with a one-cycle
// valid strobe.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset
//   i_digit        BCD digit (10..15 are illegal and dropped)
//   i_digit_valid  i_digit is presented this cycle
//   i_sign         pulse, toggles the pending sign
//   i_enter        pulse, requests conversion
//   i_clear        pulse, aborts the entry (honoured in every state)
//   o_ready        high while digits/sign/enter are accepted
//   o_data         converted two's-complement value (holds until next convert)
//   o_valid        one-cycle pulse, o_data is new
//   o_sign         TEN while the pending/last sign is negative, else OFF
//   o_ovf          sticky magnitude overflow flag for the current entry
//   o_digit_cnt    digits accepted so far
//
// Build option:
//   DIGIT_TWOS_SAT_EN  defined   -> magnitude clamps at the int16_t limits
//                      undefined -> magnitude wraps modulo 2^17, o_ovf still
//                                   reports the out-of-range condition
// -----------------------------------------------------------------------------
package digit_twos_in_pkg;
    typedef logic signed [15:0] int16_t;
    // Segment code shared with the display path: TEN draws the minus sign.
    typedef enum logic [3:0] {
        TEN = 4'd10,
        OFF = 4'd15
    } sgmnt_e;
endpackage

module digit_twos_in
    import digit_twos_in_pkg::*;
#(
    parameter int MAX_DIGITS = 5,
    parameter int POS_LIMIT  = 32767
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] i_digit,
    input  logic       i_digit_valid,
    input  logic       i_sign,
    input  logic       i_enter,
    input  logic       i_clear,
    output logic       o_ready,
    output int16_t     o_data,
    output logic       o_valid,
    output sgmnt_e     o_sign,
    output logic       o_ovf,
    output logic [2:0] o_digit_cnt
);

    typedef enum logic [1:0] {IDLE, ACCUM, CONVERT, DONE} state_e;

    localparam logic [2:0]  MAX_CNT   = 3'(MAX_DIGITS);
    localparam logic [16:0] POS_LIM   = 17'(POS_LIMIT);
    localparam logic [20:0] NEG_LIM_W = 21'(POS_LIMIT + 1);

    state_e      state_reg, state_next;
    logic [16:0] mag_reg,   mag_next;
    logic        neg_reg,   neg_next;
    logic [2:0]  cnt_reg,   cnt_next;
    logic [15:0] data_reg,  data_next;
    logic        valid_reg, valid_next;
    logic        ovf_reg,   ovf_next;

    logic        digit_legal;
    logic [20:0] acc_wide;   // mag*10+digit without truncation, for overflow detection
    logic [16:0] mag_conv;

    assign digit_legal = i_digit_valid && (i_digit <= 4'd9);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            mag_reg   <= '0;
            neg_reg   <= 1'b0;
            cnt_reg   <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            mag_reg   <= mag_next;
            neg_reg   <= neg_next;
            cnt_reg   <= cnt_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        mag_next   = mag_reg;
        neg_next   = neg_reg;
        cnt_next   = cnt_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        ovf_next   = ovf_reg;
        acc_wide   = {4'd0, mag_reg} * 21'd10 + {17'd0, i_digit};
        mag_conv   = mag_reg;

        if (i_clear) begin
            // o_data deliberately keeps the last converted value.
            state_next = IDLE;
            mag_next   = '0;
            neg_next   = 1'b0;
            cnt_next   = '0;
            ovf_next   = 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // The first legal digit opens a new entry and discards the
                    // sign/overflow kept on display from the previous one. A
                    // sign pulse in the same cycle still applies afterwards.
                    if (digit_legal) begin
                        mag_next   = {13'd0, i_digit};
                        cnt_next   = 3'd1;
                        neg_next   = 1'b0;
                        ovf_next   = 1'b0;
                        state_next = ACCUM;
                    end
                    if (i_sign) begin
                        neg_next = ~neg_next;
                    end
                    // mag is already zero whenever IDLE is entered.
                    if (i_enter) begin
                        state_next = CONVERT;
                    end
                end
                ACCUM: begin
                    if (digit_legal && (cnt_reg < MAX_CNT)) begin
                        cnt_next = cnt_reg + 3'd1;
                        mag_next = acc_wide[16:0];
                        if (acc_wide > NEG_LIM_W) begin
                            ovf_next = 1'b1;
`ifdef DIGIT_TWOS_SAT_EN
                            mag_next = NEG_LIM_W[16:0];
`endif
                        end
                    end
                    if (i_sign) begin
                        neg_next = ~neg_reg;
                    end
                    if (i_enter) begin
                        state_next = CONVERT;
                    end
                end
                CONVERT: begin
                    // A positive number may only reach POS_LIMIT; the extra
                    // count is reserved for the negative side.
                    if (!neg_reg && (mag_reg > POS_LIM)) begin
                        ovf_next = 1'b1;
`ifdef DIGIT_TWOS_SAT_EN
                        mag_conv = POS_LIM;
`endif
                    end
                    mag_next  = mag_conv;
                    data_next = neg_reg ? (~mag_conv[15:0]) + 16'd1 : mag_conv[15:0];
                    // -0 is shown as plain 0.
                    if (mag_conv == 17'd0) begin
                        neg_next = 1'b0;
                    end
                    state_next = DONE;
                end
                DONE: begin
                    valid_next = 1'b1;
                    mag_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign o_ready     = (state_reg == IDLE) || (state_reg == ACCUM);
    assign o_data      = data_reg;
    assign o_valid     = valid_reg;
    assign o_sign      = neg_reg ? TEN : OFF;
    assign o_ovf       = ovf_reg;
    assign o_digit_cnt = cnt_reg;

endmodule

// File: tb/tb_digit_twos_in.sv
// -----------------------------------------------------------------------------
// tb_digit_twos_in
//
// Drives keypad sequences into digit_twos_in. Each enter pushes the expected
// result (value, sign, overflow, cycle of the valid pulse) onto a scoreboard;
// a monitor pops and compares whenever o_valid is seen.
// -----------------------------------------------------------------------------
module tb_digit_twos_in;
    import digit_twos_in_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] i_digit;
    logic       i_digit_valid;
    logic       i_sign;
    logic       i_enter;
    logic       i_clear;
    logic       o_ready;
    int16_t     o_data;
    logic       o_valid;
    sgmnt_e     o_sign;
    logic       o_ovf;
    logic [2:0] o_digit_cnt;

    typedef struct {
        logic [15:0] data;
        sgmnt_e      sign;
        logic        ovf;
        int          vcyc;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    digit_twos_in dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_digit       (i_digit),
        .i_digit_valid (i_digit_valid),
        .i_sign        (i_sign),
        .i_enter       (i_enter),
        .i_clear       (i_clear),
        .o_ready       (o_ready),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_sign        (o_sign),
        .o_ovf         (o_ovf),
        .o_digit_cnt   (o_digit_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs change on the falling edge and are sampled on the next rising edge.
    task automatic drive(input logic [3:0] d, input logic dv, input logic s,
                         input logic e, input logic c);
        @(negedge clk);
        i_digit       = d;
        i_digit_valid = dv;
        i_sign        = s;
        i_enter       = e;
        i_clear       = c;
    endtask

    task automatic idle();
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input logic [3:0] d);
        drive(d, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // Called right after the enter cycle has been driven: valid is due three
    // rising edges later (convert, done, valid register).
    task automatic expect_result(input logic [15:0] data, input sgmnt_e sign, input logic ovf);
        exp_t e;
        e.data = data;
        e.sign = sign;
        e.ovf  = ovf;
        e.vcyc = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic enter_expect(input logic [15:0] data, input sgmnt_e sign, input logic ovf);
        drive(4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_result(data, sign, ovf);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        idle();
        idle();
    endtask

    always @(negedge clk) begin
        if (rst_n && o_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", {31'd0, o_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("conversion: data=%h sign=%s ovf=%0b cycle=%0d", o_data, o_sign.name(), o_ovf, cyc);
                chk("data",    {16'd0, o_data}, {16'd0, e.data});
                chk("sign",    32'(o_sign),     32'(e.sign));
                chk("ovf",     {31'd0, o_ovf},  {31'd0, e.ovf});
                chk("latency", cyc,             e.vcyc);
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        i_digit       = 4'd0;
        i_digit_valid = 1'b0;
        i_sign        = 1'b0;
        i_enter       = 1'b0;
        i_clear       = 1'b0;

        // Reset with garbage on the inputs.
        repeat (3) begin
            drive(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end
        idle();
        chk("rst_data",  {16'd0, o_data},    32'd0);
        chk("rst_valid", {31'd0, o_valid},   32'd0);
        chk("rst_sign",  32'(o_sign),        32'(OFF));
        chk("rst_ovf",   {31'd0, o_ovf},     32'd0);
        chk("rst_ready", {31'd0, o_ready},   32'd1);
        chk("rst_cnt",   {29'd0, o_digit_cnt}, 32'd0);
        rst_n = 1'b1;
        idle();

        // 123
        key(4'd1); key(4'd2); key(4'd3);
        enter_expect(16'd123, OFF, 1'b0);
        idle();
        chk("ready_low_convert", {31'd0, o_ready}, 32'd0);
        drain();
        chk("ready_after_done", {31'd0, o_ready}, 32'd1);

        // -32768
        key(4'd3); key(4'd2); key(4'd7); key(4'd6); key(4'd8);
        drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        enter_expect(16'h8000, TEN, 1'b0);
        drain();

        // 99999: clamps or wraps
        repeat (5) key(4'd9);
`ifdef DIGIT_TWOS_SAT_EN
        enter_expect(16'd32767, OFF, 1'b1);
`else
        enter_expect(16'h869F, OFF, 1'b1);
`endif
        drain();

        // Last digit together with enter; overflow cleared by new entry.
        key(4'd4); key(4'd5);
        drive(4'd6, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_result(16'd456, OFF, 1'b0);
        drain();

        // Clear aborts, o_data keeps last result; double sign, illegal digit.
        key(4'd7); key(4'd7);
        drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("clear_keeps_data", {16'd0, o_data},      32'd456);
        chk("clear_cnt",        {29'd0, o_digit_cnt}, 32'd0);
        key(4'd5);
        drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        key(4'd11);
        idle();
        chk("cnt_before_enter", {29'd0, o_digit_cnt}, 32'd1);
        chk("sign_twice",       32'(o_sign),          32'(OFF));
        enter_expect(16'd5, OFF, 1'b0);
        drain();

        // Sixth digit dropped.
        for (int d = 1; d <= 6; d++) key(4'(d));
        idle();
        chk("cnt_max", {29'd0, o_digit_cnt}, 32'd5);
        enter_expect(16'd12345, OFF, 1'b0);
        drain();

        // -0 from IDLE shows as 0 with sign OFF.
        drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("pending_sign", 32'(o_sign), 32'(TEN));
        enter_expect(16'd0, OFF, 1'b0);
        drain();

        // Negative overflow: -40000.
        key(4'd4); key(4'd0); key(4'd0); key(4'd0); key(4'd0);
        drive(4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef DIGIT_TWOS_SAT_EN
        enter_expect(16'h8000, TEN, 1'b1);
`else
        enter_expect(16'h63C0, TEN, 1'b1);
`endif
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
